// File: rtl/vx_dispatch_lane_splitter.sv
// Splits one dispatch packet into NUM_THREADS/NUM_LANES lane-group sub-packets.
// Define VX_LANE_SKIP_EN to skip lane groups whose thread-mask slice is empty.
module vx_dispatch_lane_splitter #(
    parameter int unsigned NUM_THREADS = 4,
    parameter int unsigned NUM_LANES   = 2,
    parameter int unsigned XLEN        = 32,
    parameter int unsigned HDR_W       = 128,
    localparam int         NUM_PKTS    = int'(NUM_THREADS / NUM_LANES),
    localparam int         PID_W       = (NUM_PKTS > 1) ? $clog2(NUM_PKTS) : 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    input  logic [NUM_THREADS-1:0]        in_tmask,
    input  logic [HDR_W-1:0]              in_hdr,
    input  logic [NUM_THREADS*XLEN-1:0]   in_rs1_data,
    input  logic [NUM_THREADS*XLEN-1:0]   in_rs2_data,
    input  logic [NUM_THREADS*XLEN-1:0]   in_rs3_data,
    output logic                          in_ready,
    output logic                          out_valid,
    output logic [NUM_LANES-1:0]          out_tmask,
    output logic [HDR_W-1:0]              out_hdr,
    output logic [PID_W-1:0]              out_pid,
    output logic                          out_sop,
    output logic                          out_eop,
    output logic [NUM_LANES*XLEN-1:0]     out_rs1_data,
    output logic [NUM_LANES*XLEN-1:0]     out_rs2_data,
    output logic [NUM_LANES*XLEN-1:0]     out_rs3_data,
    input  logic                          out_ready
);

    typedef enum logic {StIdle, StSend} state_e;

    state_e                      state_q, state_d;
    logic [PID_W-1:0]            pid_q, pid_d;
    logic                        sop_q, sop_d;
    logic                        eop_q, eop_d;
    logic [NUM_THREADS-1:0]      tmask_q;
    logic [HDR_W-1:0]            hdr_q;
    logic [NUM_THREADS*XLEN-1:0] rs1_q, rs2_q, rs3_q;

    logic             accept;
    logic [PID_W-1:0] first_in, nxt;
    logic             first_last_in, nxt_last;

`ifdef VX_LANE_SKIP_EN
    // Priority-encode the lowest non-empty group (first) and the next one above pid_q.
    always_comb begin
        first_in      = '0;
        nxt           = pid_q;
        first_last_in = 1'b1;
        nxt_last      = 1'b1;
        for (int g = NUM_PKTS - 1; g >= 0; g--) begin
            if (|in_tmask[g*NUM_LANES +: NUM_LANES]) first_in = PID_W'(g);
            if (g > int'(pid_q) && |tmask_q[g*NUM_LANES +: NUM_LANES]) nxt = PID_W'(g);
        end
        for (int g = 0; g < NUM_PKTS; g++) begin
            if (g > int'(first_in) && |in_tmask[g*NUM_LANES +: NUM_LANES]) first_last_in = 1'b0;
            if (g > int'(nxt) && |tmask_q[g*NUM_LANES +: NUM_LANES]) nxt_last = 1'b0;
        end
    end
`else
    always_comb begin
        first_in      = '0;
        first_last_in = (NUM_PKTS == 1);
        nxt           = pid_q + PID_W'(1);
        nxt_last      = (int'(pid_q) + 1 == NUM_PKTS - 1);
    end
`endif

    assign in_ready = !reset && (state_q == StIdle || (out_ready && eop_q));
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        pid_d   = pid_q;
        sop_d   = sop_q;
        eop_d   = eop_q;
        if (state_q == StSend && out_ready) begin
            if (eop_q) begin
                state_d = StIdle;
                pid_d   = '0;
                sop_d   = 1'b0;
                eop_d   = 1'b0;
            end else begin
                pid_d = nxt;
                sop_d = 1'b0;
                eop_d = nxt_last;
            end
        end
        // A new packet overrides the finish path so back-to-back packets have no bubble.
        if (accept) begin
            state_d = StSend;
            pid_d   = first_in;
            sop_d   = 1'b1;
            eop_d   = first_last_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            pid_q   <= '0;
            sop_q   <= 1'b0;
            eop_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pid_q   <= pid_d;
            sop_q   <= sop_d;
            eop_q   <= eop_d;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            tmask_q <= in_tmask;
            hdr_q   <= in_hdr;
            rs1_q   <= in_rs1_data;
            rs2_q   <= in_rs2_data;
            rs3_q   <= in_rs3_data;
        end
    end

    assign out_valid    = (state_q == StSend);
    assign out_pid      = pid_q;
    assign out_sop      = sop_q;
    assign out_eop      = eop_q;
    assign out_hdr      = hdr_q;
    assign out_tmask    = tmask_q[int'(pid_q)*NUM_LANES +: NUM_LANES];
    assign out_rs1_data = rs1_q[int'(pid_q)*NUM_LANES*XLEN +: NUM_LANES*XLEN];
    assign out_rs2_data = rs2_q[int'(pid_q)*NUM_LANES*XLEN +: NUM_LANES*XLEN];
    assign out_rs3_data = rs3_q[int'(pid_q)*NUM_LANES*XLEN +: NUM_LANES*XLEN];

endmodule

// File: tb/tb_vx_dispatch_lane_splitter.sv
// Directed bench for vx_dispatch_lane_splitter with NUM_THREADS=4, NUM_LANES=2, XLEN=32.
module tb_vx_dispatch_lane_splitter;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic [3:0]   in_tmask;
    logic [127:0] in_hdr;
    logic [127:0] in_rs1_data, in_rs2_data, in_rs3_data;
    logic         in_ready;
    logic         out_valid;
    logic [1:0]   out_tmask;
    logic [127:0] out_hdr;
    logic [0:0]   out_pid;
    logic         out_sop, out_eop;
    logic [63:0]  out_rs1_data, out_rs2_data, out_rs3_data;
    logic         out_ready;

    int total = 0;
    int bad   = 0;

    localparam logic [31:0] A = 32'hA0A0_0001, B = 32'hB0B0_0002;
    localparam logic [31:0] C = 32'hC0C0_0003, D = 32'hD0D0_0004;
    localparam logic [31:0] E = 32'hE0E0_0005, F = 32'hF0F0_0006;
    localparam logic [31:0] G = 32'h1111_0007, H = 32'h2222_0008;
    localparam logic [127:0] HDR1 = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    localparam logic [127:0] HDR2 = 128'hDEAD_BEEF_0000_FFFF_5A5A_A5A5_C3C3_3C3C;

    vx_dispatch_lane_splitter #(
        .NUM_THREADS(4),
        .NUM_LANES  (2),
        .XLEN       (32),
        .HDR_W      (128)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_tmask    (in_tmask),
        .in_hdr      (in_hdr),
        .in_rs1_data (in_rs1_data),
        .in_rs2_data (in_rs2_data),
        .in_rs3_data (in_rs3_data),
        .in_ready    (in_ready),
        .out_valid   (out_valid),
        .out_tmask   (out_tmask),
        .out_hdr     (out_hdr),
        .out_pid     (out_pid),
        .out_sop     (out_sop),
        .out_eop     (out_eop),
        .out_rs1_data(out_rs1_data),
        .out_rs2_data(out_rs2_data),
        .out_rs3_data(out_rs3_data),
        .out_ready   (out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic check_sub(input string tag, input logic pid, input logic [1:0] tm,
                             input logic sop, input logic eop);
        check({tag, ".valid"}, out_valid, 1'b1);
        check({tag, ".pid"},   out_pid,   pid);
        check({tag, ".tmask"}, out_tmask, tm);
        check({tag, ".sop"},   out_sop,   sop);
        check({tag, ".eop"},   out_eop,   eop);
    endtask

    initial begin
        reset       = 1'b1;
        in_valid    = 1'b0;
        in_tmask    = '0;
        in_hdr      = '0;
        in_rs1_data = '0;
        in_rs2_data = '0;
        in_rs3_data = '0;
        out_ready   = 1'b1;

        // Reset state
        tick(); tick(); settle();
        check("rst.valid", out_valid, 1'b0);
        check("rst.in_ready", in_ready, 1'b0);
        check("rst.sop", out_sop, 1'b0);
        check("rst.eop", out_eop, 1'b0);
        check("rst.pid", out_pid, 1'b0);
        reset = 1'b0;
        settle();
        check("idle.in_ready", in_ready, 1'b1);

        // Full mask, free-flowing consumer
        in_valid = 1'b1; in_tmask = 4'b1111; in_hdr = HDR1;
        in_rs1_data = {D, C, B, A}; in_rs2_data = {H, G, F, E}; in_rs3_data = {A, B, C, D};
        tick();
        in_valid = 1'b0; settle();
        check_sub("full.p0", 1'b0, 2'b11, 1'b1, 1'b0);
        check("full.p0.rs1", out_rs1_data, {B, A});
        check("full.p0.rs2", out_rs2_data, {F, E});
        check("full.p0.rs3", out_rs3_data, {C, D});
        check("full.p0.hdr", out_hdr, HDR1);
        check("full.p0.in_ready", in_ready, 1'b0);
        tick(); settle();
        check_sub("full.p1", 1'b1, 2'b11, 1'b0, 1'b1);
        check("full.p1.rs1", out_rs1_data, {D, C});
        check("full.p1.rs3", out_rs3_data, {A, B});
        check("full.p1.in_ready", in_ready, 1'b1);
        tick(); settle();
        check("full.done.valid", out_valid, 1'b0);

        // Upper group only
        in_valid = 1'b1; in_tmask = 4'b1100; in_hdr = HDR2;
        tick();
        in_valid = 1'b0; settle();
`ifdef VX_LANE_SKIP_EN
        check_sub("hi.p1", 1'b1, 2'b11, 1'b1, 1'b1);
        check("hi.p1.rs1", out_rs1_data, {D, C});
        tick(); settle();
        check("hi.done.valid", out_valid, 1'b0);
`else
        check_sub("hi.p0", 1'b0, 2'b00, 1'b1, 1'b0);
        check("hi.p0.rs1", out_rs1_data, {B, A});
        tick(); settle();
        check_sub("hi.p1", 1'b1, 2'b11, 1'b0, 1'b1);
        check("hi.p1.hdr", out_hdr, HDR2);
        tick(); settle();
        check("hi.done.valid", out_valid, 1'b0);
`endif

        // Back-pressure: outputs hold for 3 cycles
        out_ready = 1'b0;
        in_valid = 1'b1; in_tmask = 4'b1111; in_hdr = HDR1;
        in_rs1_data = {D, C, B, A};
        tick();
        in_valid = 1'b0; settle();
        for (int i = 0; i < 3; i++) begin
            check_sub("bp.hold", 1'b0, 2'b11, 1'b1, 1'b0);
            check("bp.hold.rs1", out_rs1_data, {B, A});
            check("bp.hold.in_ready", in_ready, 1'b0);
            tick(); settle();
        end
        out_ready = 1'b1; settle();
        check_sub("bp.rel.p0", 1'b0, 2'b11, 1'b1, 1'b0);
        tick(); settle();
        check_sub("bp.p1", 1'b1, 2'b11, 1'b0, 1'b1);
        check("bp.p1.rs1", out_rs1_data, {D, C});
        tick(); settle();
        check("bp.done.valid", out_valid, 1'b0);

        // Back-to-back packets with no bubble
        in_valid = 1'b1; in_tmask = 4'b1111; in_hdr = HDR1;
        in_rs1_data = {D, C, B, A};
        tick();
        in_hdr = HDR2; in_rs1_data = {H, G, F, E}; settle();
        check_sub("b2b.a0", 1'b0, 2'b11, 1'b1, 1'b0);
        check("b2b.a0.in_ready", in_ready, 1'b0);
        check("b2b.a0.rs1", out_rs1_data, {B, A});
        tick(); settle();
        check_sub("b2b.a1", 1'b1, 2'b11, 1'b0, 1'b1);
        check("b2b.a1.in_ready", in_ready, 1'b1);
        check("b2b.a1.rs1", out_rs1_data, {D, C});
        tick();
        in_valid = 1'b0; settle();
        check_sub("b2b.b0", 1'b0, 2'b11, 1'b1, 1'b0);
        check("b2b.b0.rs1", out_rs1_data, {F, E});
        check("b2b.b0.hdr", out_hdr, HDR2);
        tick(); settle();
        check_sub("b2b.b1", 1'b1, 2'b11, 1'b0, 1'b1);
        check("b2b.b1.rs1", out_rs1_data, {H, G});
        tick(); settle();
        check("b2b.done.valid", out_valid, 1'b0);

        // Reset right after acceptance kills the packet
        in_valid = 1'b1; in_tmask = 4'b1111; in_hdr = HDR1;
        in_rs1_data = {D, C, B, A};
        tick();
        in_valid = 1'b0; settle();
        check_sub("rstmid.p0", 1'b0, 2'b11, 1'b1, 1'b0);
        reset = 1'b1; settle();
        check("rstmid.in_ready_hi", in_ready, 1'b0);
        tick();
        reset = 1'b0; settle();
        check("rstmid.valid", out_valid, 1'b0);
        check("rstmid.in_ready", in_ready, 1'b1);
        tick(); settle();
        check("rstmid.no_p1", out_valid, 1'b0);

        // Empty mask
        in_valid = 1'b1; in_tmask = 4'b0000; in_hdr = HDR2;
        tick();
        in_valid = 1'b0; settle();
`ifdef VX_LANE_SKIP_EN
        check_sub("empty.p0", 1'b0, 2'b00, 1'b1, 1'b1);
        check("empty.p0.hdr", out_hdr, HDR2);
        tick(); settle();
        check("empty.done.valid", out_valid, 1'b0);
`else
        check_sub("empty.p0", 1'b0, 2'b00, 1'b1, 1'b0);
        check("empty.p0.hdr", out_hdr, HDR2);
        tick(); settle();
        check_sub("empty.p1", 1'b1, 2'b00, 1'b0, 1'b1);
        check("empty.p1.hdr", out_hdr, HDR2);
        tick(); settle();
        check("empty.done.valid", out_valid, 1'b0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
